// File: rtl/ifetch_tl_arb_pkg.sv
// Shared TileLink constants and requester identifiers for the instruction-fetch arbiter.
package ifetch_tl_arb_pkg;

  // TileLink-UL opcodes used by the fetch path
  localparam logic [2:0] TlGet           = 3'd4;
  localparam logic [2:0] TlAccessAckData = 3'd1;

  // Requester identity: demand fetch (r0) and prefetch (r1)
  typedef enum logic {
    ReqR0 = 1'b0,
    ReqR1 = 1'b1
  } req_id_e;

endpackage

// File: rtl/ifetch_tl_src_alloc.sv
// TileLink source allocator: busy bitmap, lowest-free pick, per-source owner table and
// an outstanding count. The pick looks only at the registered bitmap, so a source freed
// this cycle becomes allocatable on the next one.
module ifetch_tl_src_alloc
  import ifetch_tl_arb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = 2,
  parameter int unsigned CNT_W   = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               alloc_en,
  input  req_id_e            alloc_owner,
  input  logic               free_en,
  input  logic [SRC_W-1:0]   free_src,
  output logic [NUM_SRC-1:0] busy,
  output logic [NUM_SRC-1:0] owner,
  output logic               free_any,
  output logic [SRC_W-1:0]   free_idx,
  output logic [CNT_W-1:0]   outstanding
);

  logic [NUM_SRC-1:0] busy_q, busy_d;
  logic [NUM_SRC-1:0] owner_q, owner_d;

  // Lowest-index free source; scanning downward lets the lowest index win
  always_comb begin
    free_any = 1'b0;
    free_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_any = 1'b1;
        free_idx = SRC_W'(i);
      end
    end
  end

  // Next busy/owner state; free and allocate never target the same source
  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (free_en && (free_src == SRC_W'(i))) busy_d[i] = 1'b0;
      if (alloc_en && (free_idx == SRC_W'(i))) begin
        busy_d[i]  = 1'b1;
        owner_d[i] = (alloc_owner == ReqR1);
      end
    end
  end

  // Bitmap and owner table registers
  always_ff @(posedge clock) begin
    if (reset) begin
      busy_q  <= '0;
      owner_q <= '0;
    end else begin
      busy_q  <= busy_d;
      owner_q <= owner_d;
    end
  end

  // Population count of busy sources
  always_comb begin
    outstanding = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      outstanding = outstanding + CNT_W'(busy_q[i]);
    end
  end

  assign busy  = busy_q;
  assign owner = owner_q;

endmodule

// File: rtl/ifetch_tl_arb.sv
// Instruction-fetch TileLink arbiter: round-robin between demand fetch (r0) and prefetch
// (r1), one-slot A-channel register issuing Gets, D-channel routing by source owner.
// Optional macro IFETCH_TL_ARB_SRC_CHECK_EN adds the sticky err_unexp_src output.
module ifetch_tl_arb
  import ifetch_tl_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned CNT_W  = $clog2(NUM_SRC + 1),
  localparam int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req_valid,
  output logic              r0_req_ready,
  input  logic [ADDR_W-1:0] r0_req_addr,
  input  logic              r1_req_valid,
  output logic              r1_req_ready,
  input  logic [ADDR_W-1:0] r1_req_addr,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [2:0]        a_opcode,
  output logic [2:0]        a_param,
  output logic [2:0]        a_size,
  output logic [SRC_W-1:0]  a_source,
  output logic [ADDR_W-1:0] a_address,
  output logic [STRB_W-1:0] a_mask,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [SRC_W-1:0]  d_source,
  input  logic [DATA_W-1:0] d_data,
  input  logic              d_denied,
  input  logic              d_corrupt,
  output logic              r0_rsp_valid,
  input  logic              r0_rsp_ready,
  output logic [DATA_W-1:0] r0_rsp_data,
  output logic              r0_rsp_err,
  output logic              r1_rsp_valid,
  input  logic              r1_rsp_ready,
  output logic [DATA_W-1:0] r1_rsp_data,
  output logic              r1_rsp_err,
  output logic [CNT_W-1:0]  outstanding
`ifdef IFETCH_TL_ARB_SRC_CHECK_EN
  ,
  output logic              err_unexp_src
`endif
);

  localparam int unsigned OFF_W = $clog2(STRB_W);
  localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(STRB_W - 1);

  logic               a_valid_q;
  logic [ADDR_W-1:0]  a_addr_q;
  logic [SRC_W-1:0]   a_src_q;
  req_id_e            rr_pref_q;  // requester favoured when both are valid
  req_id_e            winner;
  logic               accept;
  logic [NUM_SRC-1:0] busy, owner;
  logic               free_any;
  logic [SRC_W-1:0]   free_idx;
  logic               d_busy, d_owner, d_fire;

  // Winner selection: alternate under contention, otherwise take whoever is asking
  always_comb begin
    if (r0_req_valid && r1_req_valid) winner = rr_pref_q;
    else if (r1_req_valid)            winner = ReqR1;
    else                              winner = ReqR0;
  end

  assign accept = !reset && (!a_valid_q || a_ready) && free_any &&
                  (r0_req_valid || r1_req_valid);
  assign r0_req_ready = accept && (winner == ReqR0);
  assign r1_req_ready = accept && (winner == ReqR1);

  // A-channel slot and round-robin pointer
  always_ff @(posedge clock) begin
    if (reset) begin
      a_valid_q <= 1'b0;
      a_addr_q  <= '0;
      a_src_q   <= '0;
      rr_pref_q <= ReqR0;
    end else if (accept) begin
      a_valid_q <= 1'b1;
      a_addr_q  <= ((winner == ReqR1) ? r1_req_addr : r0_req_addr) & AlignMask;
      a_src_q   <= free_idx;
      rr_pref_q <= (winner == ReqR0) ? ReqR1 : ReqR0;
    end else if (a_ready) begin
      a_valid_q <= 1'b0;
    end
  end

  assign a_valid   = a_valid_q;
  assign a_opcode  = TlGet;
  assign a_param   = 3'd0;
  assign a_size    = 3'(OFF_W);
  assign a_source  = a_src_q;
  assign a_address = a_addr_q;
  assign a_mask    = '1;

  // Look up busy/owner state of the responding source
  always_comb begin
    d_busy  = 1'b0;
    d_owner = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (d_source == SRC_W'(i)) begin
        d_busy  = busy[i];
        d_owner = owner[i];
      end
    end
  end

  // Beats for idle sources are swallowed so a stray response cannot wedge the channel
  assign d_ready      = d_busy ? (d_owner ? r1_rsp_ready : r0_rsp_ready) : 1'b1;
  assign d_fire       = d_valid && d_ready;
  assign r0_rsp_valid = d_valid && d_busy && !d_owner;
  assign r1_rsp_valid = d_valid && d_busy && d_owner;
  assign r0_rsp_data  = d_data;
  assign r1_rsp_data  = d_data;
  assign r0_rsp_err   = d_denied || d_corrupt;
  assign r1_rsp_err   = d_denied || d_corrupt;

  ifetch_tl_src_alloc #(
    .NUM_SRC (NUM_SRC),
    .SRC_W   (SRC_W),
    .CNT_W   (CNT_W)
  ) u_src_alloc (
    .clock       (clock),
    .reset       (reset),
    .alloc_en    (accept),
    .alloc_owner (winner),
    .free_en     (d_fire && d_busy),
    .free_src    (d_source),
    .busy        (busy),
    .owner       (owner),
    .free_any    (free_any),
    .free_idx    (free_idx),
    .outstanding (outstanding)
  );

`ifdef IFETCH_TL_ARB_SRC_CHECK_EN
  logic err_q;

  // Sticky flag for a response arriving on a source nobody is waiting on
  always_ff @(posedge clock) begin
    if (reset)                   err_q <= 1'b0;
    else if (d_fire && !d_busy)  err_q <= 1'b1;
  end

  assign err_unexp_src = err_q;
`endif

endmodule

// File: tb/tb_ifetch_tl_arb.sv
// Self-checking bench for ifetch_tl_arb: directed vector table, hand-written corner
// sequences and randomized traffic checked against a transaction-level reference model.
module tb_ifetch_tl_arb;

  logic        clock, reset;
  logic        r0_req_valid, r0_req_ready, r1_req_valid, r1_req_ready;
  logic [31:0] r0_req_addr, r1_req_addr;
  logic        a_valid, a_ready;
  logic [2:0]  a_opcode, a_param, a_size;
  logic [1:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic        d_valid, d_ready;
  logic [1:0]  d_source;
  logic [31:0] d_data;
  logic        d_denied, d_corrupt;
  logic        r0_rsp_valid, r0_rsp_ready, r0_rsp_err;
  logic        r1_rsp_valid, r1_rsp_ready, r1_rsp_err;
  logic [31:0] r0_rsp_data, r1_rsp_data;
  logic [2:0]  outstanding;
  logic        err_unexp_src;

  int n_cmp  = 0;
  int n_fail = 0;

  ifetch_tl_arb dut (
    .clock        (clock),
    .reset        (reset),
    .r0_req_valid (r0_req_valid),
    .r0_req_ready (r0_req_ready),
    .r0_req_addr  (r0_req_addr),
    .r1_req_valid (r1_req_valid),
    .r1_req_ready (r1_req_ready),
    .r1_req_addr  (r1_req_addr),
    .a_valid      (a_valid),
    .a_ready      (a_ready),
    .a_opcode     (a_opcode),
    .a_param      (a_param),
    .a_size       (a_size),
    .a_source     (a_source),
    .a_address    (a_address),
    .a_mask       (a_mask),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_source     (d_source),
    .d_data       (d_data),
    .d_denied     (d_denied),
    .d_corrupt    (d_corrupt),
    .r0_rsp_valid (r0_rsp_valid),
    .r0_rsp_ready (r0_rsp_ready),
    .r0_rsp_data  (r0_rsp_data),
    .r0_rsp_err   (r0_rsp_err),
    .r1_rsp_valid (r1_rsp_valid),
    .r1_rsp_ready (r1_rsp_ready),
    .r1_rsp_data  (r1_rsp_data),
    .r1_rsp_err   (r1_rsp_err),
    .outstanding  (outstanding)
`ifdef IFETCH_TL_ARB_SRC_CHECK_EN
    ,
    .err_unexp_src (err_unexp_src)
`endif
  );

`ifndef IFETCH_TL_ARB_SRC_CHECK_EN
  assign err_unexp_src = 1'b0;
`endif

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model (transaction rules) ----------------
  bit [3:0]  m_busy, m_owner;
  bit        m_av, m_pref, m_err;
  bit [31:0] m_aaddr;
  int        m_asrc;
  // per-cycle decisions shared between check and update
  bit        c_acc, c_win, c_hit, c_own, c_dr;
  int        c_free;

  task automatic model_reset();
    m_busy = '0; m_owner = '0; m_av = 0; m_pref = 0; m_err = 0; m_aaddr = '0; m_asrc = 0;
  endtask

  task automatic check_model();
    bit any_free;
    any_free = 0;
    c_free   = 0;
    for (int i = 0; i < 4; i++) begin
      if (!any_free && !m_busy[i]) begin
        any_free = 1;
        c_free   = i;
      end
    end
    c_acc = !reset && (!m_av || a_ready) && any_free && (r0_req_valid || r1_req_valid);
    if (r0_req_valid && r1_req_valid) c_win = m_pref;
    else                              c_win = r1_req_valid;
    c_hit = m_busy[d_source];
    c_own = m_owner[d_source];
    c_dr  = c_hit ? (c_own ? r1_rsp_ready : r0_rsp_ready) : 1'b1;

    chk("r0_req_ready", 32'(r0_req_ready), 32'(c_acc && !c_win));
    chk("r1_req_ready", 32'(r1_req_ready), 32'(c_acc && c_win));
    chk("a_valid", 32'(a_valid), 32'(m_av));
    if (m_av) begin
      chk("a_address", a_address, m_aaddr);
      chk("a_source", 32'(a_source), 32'(m_asrc));
      chk("a_opcode", 32'(a_opcode), 32'd4);
      chk("a_param", 32'(a_param), 32'd0);
      chk("a_size", 32'(a_size), 32'd2);
      chk("a_mask", 32'(a_mask), 32'hf);
    end
    chk("outstanding", 32'(outstanding), 32'($countones(m_busy)));
    chk("d_ready", 32'(d_ready), 32'(c_dr));
    chk("r0_rsp_valid", 32'(r0_rsp_valid), 32'(d_valid && c_hit && !c_own));
    chk("r1_rsp_valid", 32'(r1_rsp_valid), 32'(d_valid && c_hit && c_own));
    chk("r0_rsp_err", 32'(r0_rsp_err), 32'(d_denied || d_corrupt));
    chk("r1_rsp_err", 32'(r1_rsp_err), 32'(d_denied || d_corrupt));
    if (r0_rsp_valid || r1_rsp_valid) begin
      chk("rsp_data", r0_rsp_valid ? r0_rsp_data : r1_rsp_data, d_data);
    end
`ifdef IFETCH_TL_ARB_SRC_CHECK_EN
    chk("err_unexp_src", 32'(err_unexp_src), 32'(m_err));
`endif
  endtask

  task automatic model_update();
    if (reset) begin
      model_reset();
    end else begin
      if (d_valid && c_dr && c_hit) m_busy[d_source] = 1'b0;
      if (d_valid && !c_hit)        m_err = 1'b1;
      if (c_acc) begin
        m_busy[c_free]  = 1'b1;
        m_owner[c_free] = c_win;
        m_av            = 1'b1;
        m_aaddr         = (c_win ? r1_req_addr : r0_req_addr) & ~32'h3;
        m_asrc          = c_free;
        m_pref          = !c_win;
      end else if (a_ready) begin
        m_av = 1'b0;
      end
    end
  endtask

  task automatic step_nodelay();
    check_model();
    model_update();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic step();
    #1;
    step_nodelay();
  endtask

  task automatic idle_inputs();
    r0_req_valid = 0; r1_req_valid = 0; a_ready = 0; d_valid = 0; d_source = 0;
    d_denied = 0; d_corrupt = 0; r0_rsp_ready = 0; r1_rsp_ready = 0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic rst, v0, v1, ar, dv;
    logic [1:0] ds;
    logic den, rr0, rr1;
    logic e_r0, e_r1, e_av;
    logic [31:0] e_aa;
    logic [1:0] e_as;
    logic [2:0] e_out;
    logic e_dr, e_rv0, e_rv1, e_err;
  } vec_t;

  vec_t tbl[16];
  logic [1:0] exp_src [4];
  logic       exp_g   [4];

  initial begin
    // rst v0 v1 ar dv ds den rr0 rr1 | r0 r1 av aa as out dr rv0 rv1 err
    tbl[0]  = '{1,1,0,0,0,0,0,0,0, 0,0,0,32'h0,   0,0,1,0,0,0};
    tbl[1]  = '{0,1,0,1,0,0,0,0,0, 1,0,0,32'h0,   0,0,1,0,0,0};
    tbl[2]  = '{0,0,0,0,0,0,0,0,0, 0,0,1,32'h1000,0,1,0,0,0,0};
    tbl[3]  = '{0,0,0,1,0,0,0,0,0, 0,0,1,32'h1000,0,1,0,0,0,0};
    tbl[4]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,32'h0,   0,1,0,0,0,0};
    tbl[5]  = '{0,0,0,0,1,0,0,0,0, 0,0,0,32'h0,   0,1,0,1,0,0};
    tbl[6]  = '{0,0,0,0,1,0,0,1,0, 0,0,0,32'h0,   0,1,1,1,0,0};
    tbl[7]  = '{0,0,0,0,1,3,1,0,0, 0,0,0,32'h0,   0,0,1,0,0,0};
    tbl[8]  = '{0,0,0,0,0,0,0,0,0, 0,0,0,32'h0,   0,0,1,0,0,1};
    tbl[9]  = '{0,1,1,1,0,0,0,0,0, 0,1,0,32'h0,   0,0,1,0,0,1};
    tbl[10] = '{0,1,1,1,0,0,0,0,0, 1,0,1,32'h2004,0,1,0,0,0,1};
    tbl[11] = '{0,0,0,0,0,0,0,0,0, 0,0,1,32'h1000,1,2,0,0,0,1};
    tbl[12] = '{1,1,0,0,0,0,0,0,0, 0,0,1,32'h1000,1,2,0,0,0,1};
    tbl[13] = '{0,0,0,0,0,0,0,0,0, 0,0,0,32'h0,   0,0,1,0,0,0};
    tbl[14] = '{0,0,0,0,1,1,0,0,0, 0,0,0,32'h0,   0,0,1,0,0,0};
    tbl[15] = '{0,0,0,0,0,0,0,0,0, 0,0,0,32'h0,   0,0,1,0,0,1};

    idle_inputs();
    r0_req_addr = 32'h1003;
    r1_req_addr = 32'h2007;
    d_data      = '0;
    reset       = 1;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    model_reset();

    for (int i = 0; i < 16; i++) begin
      reset        = tbl[i].rst;
      r0_req_valid = tbl[i].v0;
      r1_req_valid = tbl[i].v1;
      a_ready      = tbl[i].ar;
      d_valid      = tbl[i].dv;
      d_source     = tbl[i].ds;
      d_denied     = tbl[i].den;
      r0_rsp_ready = tbl[i].rr0;
      r1_rsp_ready = tbl[i].rr1;
      d_data       = 32'hd000_0000 | 32'(i);
      #1;
      chk($sformatf("tbl%0d r0_req_ready", i), 32'(r0_req_ready), 32'(tbl[i].e_r0));
      chk($sformatf("tbl%0d r1_req_ready", i), 32'(r1_req_ready), 32'(tbl[i].e_r1));
      chk($sformatf("tbl%0d a_valid", i), 32'(a_valid), 32'(tbl[i].e_av));
      if (tbl[i].e_av) begin
        chk($sformatf("tbl%0d a_address", i), a_address, tbl[i].e_aa);
        chk($sformatf("tbl%0d a_source", i), 32'(a_source), 32'(tbl[i].e_as));
      end
      chk($sformatf("tbl%0d outstanding", i), 32'(outstanding), 32'(tbl[i].e_out));
      chk($sformatf("tbl%0d d_ready", i), 32'(d_ready), 32'(tbl[i].e_dr));
      chk($sformatf("tbl%0d r0_rsp_valid", i), 32'(r0_rsp_valid), 32'(tbl[i].e_rv0));
      chk($sformatf("tbl%0d r1_rsp_valid", i), 32'(r1_rsp_valid), 32'(tbl[i].e_rv1));
`ifdef IFETCH_TL_ARB_SRC_CHECK_EN
      chk($sformatf("tbl%0d err_unexp_src", i), 32'(err_unexp_src), 32'(tbl[i].e_err));
`endif
      step_nodelay();
    end

    // ---- contention: grants alternate r0,r1,r0,r1 on sources 0..3 ----
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
    exp_src[0] = 0; exp_src[1] = 1; exp_src[2] = 2; exp_src[3] = 3;
    for (int k = 0; k < 4; k++) begin
      r0_req_valid = 1; r1_req_valid = 1; a_ready = 1;
      r0_req_addr = 32'h100 + 32'(k * 16); r1_req_addr = 32'h900 + 32'(k * 16);
      #1;
      chk("rr r1_req_ready", 32'(r1_req_ready), 32'(exp_g[k]));
      chk("rr r0_req_ready", 32'(r0_req_ready), 32'(!exp_g[k]));
      if (k > 0) chk("rr a_source", 32'(a_source), 32'(exp_src[k-1]));
      step_nodelay();
    end
    // all sources busy: fifth Get blocked, pending A still drains
    r1_req_valid = 0;
    #1;
    chk("full a_source", 32'(a_source), 32'(exp_src[3]));
    chk("full outstanding", 32'(outstanding), 32'd4);
    chk("full r0_req_ready", 32'(r0_req_ready), 32'd0);
    step_nodelay();
    // free source 2 (owned by r0): not reusable in the same cycle
    d_valid = 1; d_source = 2; r0_rsp_ready = 1; d_data = 32'h2222_0002;
    #1;
    chk("free same-cycle r0_req_ready", 32'(r0_req_ready), 32'd0);
    chk("free r0_rsp_valid", 32'(r0_rsp_valid), 32'd1);
    step_nodelay();
    d_valid = 0; r0_rsp_ready = 0;
    #1;
    chk("realloc r0_req_ready", 32'(r0_req_ready), 32'd1);
    step_nodelay();
    r0_req_valid = 0;
    #1;
    chk("realloc a_source", 32'(a_source), 32'd2);
    step_nodelay();

    // ---- response back-pressure: source 1 owned by r1 ----
    a_ready = 0;
    d_valid = 1; d_source = 1; d_data = 32'hbeef_0001; r1_rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall d_ready", 32'(d_ready), 32'd0);
      chk("stall r0_rsp_valid", 32'(r0_rsp_valid), 32'd0);
      chk("stall r1_rsp_valid", 32'(r1_rsp_valid), 32'd1);
      step_nodelay();
    end
    r1_rsp_ready = 1;
    #1;
    chk("deliver d_ready", 32'(d_ready), 32'd1);
    chk("deliver r1_rsp_data", r1_rsp_data, 32'hbeef_0001);
    step_nodelay();
    idle_inputs();
    step();

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 3000; n++) begin
      reset        = ($urandom_range(0, 199) == 0);
      r0_req_valid = ($urandom_range(0, 9) < 7);
      r1_req_valid = ($urandom_range(0, 9) < 6);
      r0_req_addr  = $urandom;
      r1_req_addr  = $urandom;
      a_ready      = ($urandom_range(0, 9) < 6);
      d_valid      = ($urandom_range(0, 9) < 5);
      d_source     = 2'($urandom_range(0, 3));
      d_data       = $urandom;
      d_denied     = ($urandom_range(0, 9) == 0);
      d_corrupt    = ($urandom_range(0, 9) == 0);
      r0_rsp_ready = ($urandom_range(0, 9) < 7);
      r1_rsp_ready = ($urandom_range(0, 9) < 7);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
